// File: rtl/asic_page_mapper_pkg.sv
// Shared constants and FSM state type for the ASIC page mapper slice.
// Debug build option: ASIC_PAGE_MAPPER_DEBUG_EN.
package asic_pkg;

  localparam logic [2:0] RMR2_TAG     = 3'b101;
  localparam logic [1:0] MAP_ASIC     = 2'b11;
  localparam logic [7:0] GA_PORT_HI   = 8'h7F;
  localparam logic [1:0] ASIC_PAGE_HI = 2'b01;

  typedef logic [1:0] asic_map_state_t;

  localparam asic_map_state_t ST_IDLE    = 2'd0;
  localparam asic_map_state_t ST_RD_WAIT = 2'd1;
  localparam asic_map_state_t ST_RD_DONE = 2'd2;

  // Sprite pixel RAM only holds a nibble per location.
  function automatic logic [7:0] sprite_mask(input logic in_sprite, input logic [7:0] d);
    return in_sprite ? {4'h0, d[3:0]} : d;
  endfunction

endpackage

// File: rtl/asic_page_mapper_if.sv
// CPU-side and ASIC-RAM-side bus of the page mapper.
// Debug outputs appear only with ASIC_PAGE_MAPPER_DEBUG_EN.
interface asic_page_mapper_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_io_wr;
  logic        cpu_mem_wr;
  logic        cpu_mem_rd;
  logic [7:0]  asic_ram_q;

  logic        asic_page_en;
  logic [2:0]  lower_rom_sel;
  logic [1:0]  lower_rom_base;
  logic [13:0] asic_ram_addr;
  logic        asic_ram_rd;
  logic        asic_ram_wr;
  logic [7:0]  asic_ram_din;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_valid;
  logic        reg_wr_evt;
`ifdef ASIC_PAGE_MAPPER_DEBUG_EN
  logic [7:0]  rmr2_shadow;
  logic [7:0]  rmr2_reject_cnt;

  modport slave (
    input  cpu_addr, cpu_data_in, cpu_io_wr, cpu_mem_wr, cpu_mem_rd, asic_ram_q,
    output asic_page_en, lower_rom_sel, lower_rom_base, asic_ram_addr, asic_ram_rd,
           asic_ram_wr, asic_ram_din, cpu_data_out, cpu_data_valid, reg_wr_evt,
           rmr2_shadow, rmr2_reject_cnt
  );

  modport master (
    output cpu_addr, cpu_data_in, cpu_io_wr, cpu_mem_wr, cpu_mem_rd, asic_ram_q,
    input  asic_page_en, lower_rom_sel, lower_rom_base, asic_ram_addr, asic_ram_rd,
           asic_ram_wr, asic_ram_din, cpu_data_out, cpu_data_valid, reg_wr_evt,
           rmr2_shadow, rmr2_reject_cnt
  );
`else
  modport slave (
    input  cpu_addr, cpu_data_in, cpu_io_wr, cpu_mem_wr, cpu_mem_rd, asic_ram_q,
    output asic_page_en, lower_rom_sel, lower_rom_base, asic_ram_addr, asic_ram_rd,
           asic_ram_wr, asic_ram_din, cpu_data_out, cpu_data_valid, reg_wr_evt
  );

  modport master (
    output cpu_addr, cpu_data_in, cpu_io_wr, cpu_mem_wr, cpu_mem_rd, asic_ram_q,
    input  asic_page_en, lower_rom_sel, lower_rom_base, asic_ram_addr, asic_ram_rd,
           asic_ram_wr, asic_ram_din, cpu_data_out, cpu_data_valid, reg_wr_evt
  );
`endif

endinterface

// File: rtl/asic_page_mapper_strobe_edge.sv
// Registered rising-edge detector for a level strobe; a held strobe yields one pulse.
module strobe_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= 1'b0;
    else       prev_q <= strobe_i;
  end

  assign rise_o = strobe_i & ~prev_q;

endmodule

// File: rtl/asic_page_mapper.sv
// RMR2 decode, lower-ROM/ASIC page mapping state and ASIC RAM access sequencer.
// Optional debug outputs: define ASIC_PAGE_MAPPER_DEBUG_EN.
module asic_page_mapper
  import asic_pkg::*;
#(
  parameter int          RAM_LATENCY = 1,
  parameter logic [13:0] SPRITE_TOP  = 14'h0FFF
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               plus_mode,
  input  logic               asic_valid,
  asic_page_mapper_if.slave  bus
);

  logic            clr;
  logic            io_rise, wr_rise, rd_rise;
  logic            rmr2_pat, rmr2_acc, page_hit;

  asic_map_state_t state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            valid_seen_q;
  logic            page_en_q, page_en_d;
  logic [2:0]      rom_sel_q, rom_sel_d;
  logic [1:0]      rom_base_q, rom_base_d;
  logic [13:0]     addr_q, addr_d;
  logic [7:0]      din_q, din_d;
  logic [7:0]      dout_q, dout_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            dvalid_q, dvalid_d;

  // plus_mode low behaves exactly like reset for every register here.
  assign clr = reset | ~plus_mode;

  strobe_edge u_io_edge (.clk_i(clk_sys), .rst_i(clr), .strobe_i(bus.cpu_io_wr),  .rise_o(io_rise));
  strobe_edge u_wr_edge (.clk_i(clk_sys), .rst_i(clr), .strobe_i(bus.cpu_mem_wr), .rise_o(wr_rise));
  strobe_edge u_rd_edge (.clk_i(clk_sys), .rst_i(clr), .strobe_i(bus.cpu_mem_rd), .rise_o(rd_rise));

  assign rmr2_pat = io_rise && (bus.cpu_addr[15:8] == GA_PORT_HI) &&
                    (bus.cpu_data_in[7:5] == RMR2_TAG);
  assign rmr2_acc = rmr2_pat && asic_valid;
  assign page_hit = page_en_q && (bus.cpu_addr[15:14] == ASIC_PAGE_HI);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    page_en_d  = page_en_q;
    rom_sel_d  = rom_sel_q;
    rom_base_d = rom_base_q;
    addr_d     = addr_q;
    din_d      = din_q;
    dout_d     = dout_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    dvalid_d   = 1'b0;

    if (rmr2_acc) begin
      rom_sel_d = bus.cpu_data_in[2:0];
      if (bus.cpu_data_in[4:3] == MAP_ASIC) begin
        page_en_d  = 1'b1;
        rom_base_d = 2'd0;
      end else begin
        page_en_d  = 1'b0;
        rom_base_d = bus.cpu_data_in[4:3];
      end
    end else if (valid_seen_q && !asic_valid) begin
      page_en_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_rise && page_hit) begin
          wr_d   = 1'b1;
          addr_d = bus.cpu_addr[13:0];
          din_d  = sprite_mask(bus.cpu_addr[13:0] <= SPRITE_TOP, bus.cpu_data_in);
        end else if (rd_rise && page_hit) begin
          rd_d    = 1'b1;
          addr_d  = bus.cpu_addr[13:0];
          cnt_d   = 2'(RAM_LATENCY - 1);
          state_d = ST_RD_WAIT;
        end
      end
      // Data and valid are registered on the way into RD_DONE so the pulse
      // coincides with the RD_DONE cycle.
      ST_RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          dout_d   = sprite_mask(addr_q <= SPRITE_TOP, bus.asic_ram_q);
          dvalid_d = 1'b1;
          state_d  = ST_RD_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RD_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      valid_seen_q <= 1'b0;
      page_en_q    <= 1'b0;
      rom_sel_q    <= '0;
      rom_base_q   <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      dout_q       <= '1;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      dvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      valid_seen_q <= asic_valid;
      page_en_q    <= page_en_d;
      rom_sel_q    <= rom_sel_d;
      rom_base_q   <= rom_base_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      dout_q       <= dout_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      dvalid_q     <= dvalid_d;
    end
  end

  assign bus.asic_page_en   = page_en_q;
  assign bus.lower_rom_sel  = rom_sel_q;
  assign bus.lower_rom_base = rom_base_q;
  assign bus.asic_ram_addr  = addr_q;
  assign bus.asic_ram_rd    = rd_q;
  assign bus.asic_ram_wr    = wr_q;
  assign bus.asic_ram_din   = din_q;
  assign bus.cpu_data_out   = dout_q;
  assign bus.cpu_data_valid = dvalid_q;
  assign bus.reg_wr_evt     = wr_q;

`ifdef ASIC_PAGE_MAPPER_DEBUG_EN
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] reject_q, reject_d;

  always_comb begin
    shadow_d = shadow_q;
    reject_d = reject_q;
    if (rmr2_acc) shadow_d = bus.cpu_data_in;
    if (rmr2_pat && !asic_valid && reject_q != 8'hFF) reject_d = reject_q + 8'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (clr) begin
      shadow_q <= 8'hA0;
      reject_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      reject_q <= reject_d;
    end
  end

  assign bus.rmr2_shadow     = shadow_q;
  assign bus.rmr2_reject_cnt = reject_q;
`endif

endmodule

// File: tb/tb_asic_page_mapper.sv
// Directed bench for asic_page_mapper with RAM_LATENCY=2.
module tb_asic_page_mapper;

  logic clk = 1'b0;
  logic reset;
  logic plus_mode;
  logic asic_valid;
  int   checks = 0;
  int   errors = 0;

  asic_page_mapper_if bus ();

  asic_page_mapper #(.RAM_LATENCY(2), .SPRITE_TOP(14'h0FFF)) dut (
    .clk_sys    (clk),
    .reset      (reset),
    .plus_mode  (plus_mode),
    .asic_valid (asic_valid),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; plus_mode = 1'b1; asic_valid = 1'b0;
    bus.cpu_addr = '0; bus.cpu_data_in = '0; bus.cpu_io_wr = 1'b0;
    bus.cpu_mem_wr = 1'b0; bus.cpu_mem_rd = 1'b0; bus.asic_ram_q = '0;
    #1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_page_en", 16'(bus.asic_page_en), 16'h0);
    chk("rst_rom_sel", 16'(bus.lower_rom_sel), 16'h0);
    chk("rst_rom_base", 16'(bus.lower_rom_base), 16'h0);
    chk("rst_addr", 16'(bus.asic_ram_addr), 16'h0);
    chk("rst_din", 16'(bus.asic_ram_din), 16'h0);
    chk("rst_dout", 16'(bus.cpu_data_out), 16'h00FF);
    chk("rst_strobes", {13'd0, bus.asic_ram_rd, bus.asic_ram_wr, bus.cpu_data_valid}, 16'h0);

    // RMR2 while locked is ignored
    bus.cpu_addr = 16'h7F00; bus.cpu_data_in = 8'hB8; bus.cpu_io_wr = 1'b1;
    tick();
    chk("locked_page_en", 16'(bus.asic_page_en), 16'h0);
    bus.cpu_io_wr = 1'b0;
    asic_valid = 1'b1;
    tick();
    bus.cpu_io_wr = 1'b1;
    tick();
    chk("unlock_page_en", 16'(bus.asic_page_en), 16'h1);
    chk("unlock_rom_base", 16'(bus.lower_rom_base), 16'h0);
    chk("unlock_rom_sel", 16'(bus.lower_rom_sel), 16'h0);
    bus.cpu_io_wr = 1'b0;
    tick();

    // sprite-area write, held strobe gives a single pulse
    bus.cpu_addr = 16'h4005; bus.cpu_data_in = 8'hA7; bus.cpu_mem_wr = 1'b1;
    tick();
    chk("wr1_wr", 16'(bus.asic_ram_wr), 16'h1);
    chk("wr1_evt", 16'(bus.reg_wr_evt), 16'h1);
    chk("wr1_addr", 16'(bus.asic_ram_addr), 16'h0005);
    chk("wr1_din", 16'(bus.asic_ram_din), 16'h0007);
    tick();
    chk("wr1_held_wr", 16'(bus.asic_ram_wr), 16'h0);
    chk("wr1_held_evt", 16'(bus.reg_wr_evt), 16'h0);
    bus.cpu_mem_wr = 1'b0;
    tick();

    // register-area write keeps all 8 bits
    bus.cpu_addr = 16'h6400; bus.cpu_mem_wr = 1'b1;
    tick();
    chk("wr2_wr", 16'(bus.asic_ram_wr), 16'h1);
    chk("wr2_evt", 16'(bus.reg_wr_evt), 16'h1);
    chk("wr2_addr", 16'(bus.asic_ram_addr), 16'h2400);
    chk("wr2_din", 16'(bus.asic_ram_din), 16'h00A7);
    bus.cpu_mem_wr = 1'b0;
    tick();

    // read &6800, latency 2: rd at N+1, valid at N+3
    bus.asic_ram_q = 8'h5C; bus.cpu_addr = 16'h6800; bus.cpu_mem_rd = 1'b1;
    tick();
    chk("rd1_rd_n1", 16'(bus.asic_ram_rd), 16'h1);
    chk("rd1_addr", 16'(bus.asic_ram_addr), 16'h2800);
    chk("rd1_valid_n1", 16'(bus.cpu_data_valid), 16'h0);
    bus.cpu_mem_rd = 1'b0;
    tick();
    chk("rd1_rd_n2", 16'(bus.asic_ram_rd), 16'h0);
    chk("rd1_valid_n2", 16'(bus.cpu_data_valid), 16'h0);
    tick();
    chk("rd1_valid_n3", 16'(bus.cpu_data_valid), 16'h1);
    chk("rd1_dout", 16'(bus.cpu_data_out), 16'h005C);
    tick();
    chk("rd1_valid_n4", 16'(bus.cpu_data_valid), 16'h0);
    chk("rd1_dout_hold", 16'(bus.cpu_data_out), 16'h005C);

    // sprite-area read masks upper nibble
    bus.asic_ram_q = 8'hF3; bus.cpu_addr = 16'h4010; bus.cpu_mem_rd = 1'b1;
    tick();
    chk("rd2_rd", 16'(bus.asic_ram_rd), 16'h1);
    bus.cpu_mem_rd = 1'b0;
    tick(); tick();
    chk("rd2_valid", 16'(bus.cpu_data_valid), 16'h1);
    chk("rd2_dout", 16'(bus.cpu_data_out), 16'h0003);
    tick();

    // simultaneous read and write rise: write wins
    bus.cpu_addr = 16'h4020; bus.cpu_data_in = 8'h3C;
    bus.cpu_mem_wr = 1'b1; bus.cpu_mem_rd = 1'b1;
    tick();
    chk("both_wr", 16'(bus.asic_ram_wr), 16'h1);
    chk("both_rd", 16'(bus.asic_ram_rd), 16'h0);
    chk("both_din", 16'(bus.asic_ram_din), 16'h000C);
    bus.cpu_mem_wr = 1'b0; bus.cpu_mem_rd = 1'b0;
    tick(); tick();
    chk("both_no_valid", 16'(bus.cpu_data_valid), 16'h0);

    // access outside the page window
    bus.cpu_addr = 16'h8000; bus.cpu_mem_rd = 1'b1;
    tick();
    chk("miss_rd", 16'(bus.asic_ram_rd), 16'h0);
    bus.cpu_mem_rd = 1'b0;
    tick();

    // RMR2 &A9: page off, ROM at &4000, ROM 1
    bus.cpu_addr = 16'h7F00; bus.cpu_data_in = 8'hA9; bus.cpu_io_wr = 1'b1;
    tick();
    chk("a9_page_en", 16'(bus.asic_page_en), 16'h0);
    chk("a9_rom_base", 16'(bus.lower_rom_base), 16'h1);
    chk("a9_rom_sel", 16'(bus.lower_rom_sel), 16'h1);
    bus.cpu_io_wr = 1'b0;
    tick();
    bus.cpu_addr = 16'h4000; bus.cpu_data_in = 8'h11; bus.cpu_mem_wr = 1'b1;
    tick();
    chk("off_wr", 16'(bus.asic_ram_wr), 16'h0);
    bus.cpu_mem_wr = 1'b0;
    tick();

    // page on then relock
    bus.cpu_addr = 16'h7F00; bus.cpu_data_in = 8'hBA; bus.cpu_io_wr = 1'b1;
    tick();
    chk("ba_page_en", 16'(bus.asic_page_en), 16'h1);
    chk("ba_rom_sel", 16'(bus.lower_rom_sel), 16'h2);
    bus.cpu_io_wr = 1'b0;
    asic_valid = 1'b0;
    tick();
    chk("relock_page_en", 16'(bus.asic_page_en), 16'h0);
    chk("relock_rom_sel", 16'(bus.lower_rom_sel), 16'h2);

    // plus_mode low clears mapping
    asic_valid = 1'b1;
    tick();
    bus.cpu_data_in = 8'hBB; bus.cpu_io_wr = 1'b1;
    tick();
    chk("bb_page_en", 16'(bus.asic_page_en), 16'h1);
    bus.cpu_io_wr = 1'b0;
    plus_mode = 1'b0;
    tick();
    chk("plus_off_page_en", 16'(bus.asic_page_en), 16'h0);
    chk("plus_off_rom_sel", 16'(bus.lower_rom_sel), 16'h0);
    chk("plus_off_dout", 16'(bus.cpu_data_out), 16'h00FF);
    plus_mode = 1'b1;
    tick();

    // reset during RD_WAIT suppresses the valid pulse
    bus.cpu_io_wr = 1'b1;
    tick();
    chk("pre_rst_page_en", 16'(bus.asic_page_en), 16'h1);
    bus.cpu_io_wr = 1'b0;
    bus.asic_ram_q = 8'h77; bus.cpu_addr = 16'h5100; bus.cpu_mem_rd = 1'b1;
    tick();
    chk("rstrd_rd", 16'(bus.asic_ram_rd), 16'h1);
    bus.cpu_mem_rd = 1'b0;
    reset = 1'b1;
    tick();
    chk("rstrd_valid_a", 16'(bus.cpu_data_valid), 16'h0);
    reset = 1'b0;
    tick();
    chk("rstrd_valid_b", 16'(bus.cpu_data_valid), 16'h0);
    tick();
    chk("rstrd_valid_c", 16'(bus.cpu_data_valid), 16'h0);
    chk("rstrd_dout", 16'(bus.cpu_data_out), 16'h00FF);
    chk("rstrd_page_en", 16'(bus.asic_page_en), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/asic_page_mapper.md
Name: asic_page_mapper

Overview:
- Sits directly downstream of the ACID unlock block and consumes its `asic_valid` output.
- Decodes RMR2 writes to the Gate Array I/O port (&7Fxx) and holds the lower-ROM/ASIC-page mapping state.
- Converts Z80 memory accesses in &4000-&7FFF into single-cycle strobes on the ASIC RAM port (`asic_ram_*`) while the ASIC page is mapped in.
- Returns read data with a registered valid pulse, and masks sprite-RAM writes to 4 bits.

Parameters:
- RAM_LATENCY, 1, ASIC RAM read latency in clk_sys cycles from `asic_ram_rd` to valid `asic_ram_q`; legal values 1 or 2.
- SPRITE_TOP, 14'h0FFF, last page offset of sprite pixel RAM. Writes at offsets 0..SPRITE_TOP store the low nibble only.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- plus_mode  in  1  Plus features enabled; when 0, all outputs are held at reset values.
- asic_valid  in  1  ASIC unlocked, from ACID unlock block.
- cpu_addr  in  16  Z80 address.
- cpu_data_in  in  8  Z80 write data.
- cpu_io_wr  in  1  I/O write strobe (level).
- cpu_mem_wr  in  1  memory write strobe (level).
- cpu_mem_rd  in  1  memory read strobe (level).
- asic_ram_q  in  8  ASIC RAM read data.
- asic_page_en  out  1  ASIC registers mapped at &4000-&7FFF.
- lower_rom_sel  out  3  lower ROM number, RMR2[2:0].
- lower_rom_base  out  2  lower ROM location: 0=&0000, 1=&4000, 2=&8000. Value 3 is never driven.
- asic_ram_addr  out  14  ASIC RAM address, cpu_addr[13:0] latched.
- asic_ram_rd  out  1  one-cycle read strobe.
- asic_ram_wr  out  1  one-cycle write strobe.
- asic_ram_din  out  8  ASIC RAM write data (masked).
- cpu_data_out  out  8  captured read data.
- cpu_data_valid  out  1  one-cycle pulse when `cpu_data_out` is updated.
- reg_wr_evt  out  1  one-cycle pulse accompanying `asic_ram_wr`, for register side-effect logic.

Behaviour:
- Reset values:
  - `asic_page_en`=0, `lower_rom_sel`=0, `lower_rom_base`=0.
  - All strobes 0; `asic_ram_addr`=0, `asic_ram_din`=0, `cpu_data_out`=8'hFF.
  - FSM in IDLE.
- Edge detection: strobes act on the rising edge only, using a registered copy of each strobe (prev=0, now=1). A held strobe produces one action.
- RMR2 decode, cycle N rising edge of `cpu_io_wr`, cpu_addr[15:8]==8'h7F, cpu_data_in[7:5]==3'b101:
  - Accepted only if `asic_valid`=1; otherwise ignored.
  - On accept, at cycle N+1: `lower_rom_sel` = data[2:0].
  - If data[4:3]==2'b11: `asic_page_en`=1 and `lower_rom_base`=0.
  - Else: `asic_page_en`=0 and `lower_rom_base`=data[4:3].
- Relock: `asic_valid` 1->0 clears `asic_page_en` on the next cycle; `lower_rom_*` are kept. The `plus_mode`=0 rule overrides this.
- Page hit = `asic_page_en` && cpu_addr[15:14]==2'b01.
- FSM states: IDLE, RD_WAIT, RD_DONE.
  - IDLE, mem_wr rise & hit:
    - `asic_ram_wr` and `reg_wr_evt` = 1 for exactly cycle N+1.
    - addr = cpu_addr[13:0].
    - din = (addr<=SPRITE_TOP) ? {4'h0, data[3:0]} : data.
    - Stay in IDLE.
  - IDLE, mem_rd rise & hit: `asic_ram_rd`=1 for cycle N+1, addr latched; go to RD_WAIT. A hold counter loads RAM_LATENCY-1.
  - RD_WAIT: counts down to 0, then goes to RD_DONE.
  - RD_DONE:
    - Capture `asic_ram_q` into `cpu_data_out`; if addr<=SPRITE_TOP, force bits[7:4]=4'h0.
    - `cpu_data_valid`=1 for one cycle; return to IDLE.
  - Total: `cpu_data_valid` at N+2+RAM_LATENCY-1.
- Simultaneous events:
  - Read and write rising in the same cycle: write wins, read dropped.
  - Strobe edges arriving while not in IDLE are ignored (no queue).
  - An RMR2 write during RD_WAIT/RD_DONE updates mapping but does not abort the read.
- No hit (page off or address outside the page): no ASIC RAM strobes; `cpu_data_out` unchanged.
- `plus_mode`=0: forces all outputs to reset values and the FSM to IDLE, the same as reset.
- Reset mid-read: FSM returns to IDLE and no `cpu_data_valid` pulse is issued.

Optional Feature:
- Macro ASIC_PAGE_MAPPER_DEBUG_EN.
- Defined, adds outputs:
  - `rmr2_shadow`[7:0]: last accepted RMR2 byte, reset 8'hA0.
  - `rmr2_reject_cnt`[7:0]: increments on each RMR2-pattern write while `asic_valid`=0; saturates at 8'hFF; reset 0.
- Undefined: ports and logic absent; functional behaviour otherwise identical.

Decomposition:
- Shared package asic_pkg:
  - RMR2 field constants: RMR2_TAG=3'b101, MAP_ASIC=2'b11.
  - `GA_PORT_HI`=8'h7F, `ASIC_PAGE_HI`=2'b01.
  - FSM typedef `asic_map_state_t`.
- One sub-module `strobe_edge` (registered rising-edge detector), instantiated three times.

Test Plan:
- Locked, then an I/O write to &7F00 with &B8 -> `asic_page_en` stays 0. Then set `asic_valid`=1 and repeat -> `asic_page_en`=1, `lower_rom_base`=0 on the next cycle.
- Page on, mem write &4005 data &A7 -> `asic_ram_wr` for one cycle, addr 14'h0005, din 8'h07. Mem write &6400 data &A7 -> din 8'hA7, `reg_wr_evt` pulses.
- Page on, RAM_LATENCY=2, mem read &6800 with RAM returning &5C -> `asic_ram_rd` at N+1; `cpu_data_valid` at N+3 with `cpu_data_out`=&5C.
- Read at &4010 with RAM returning &F3 -> `cpu_data_out`=&03.
- RMR2 write &A9 -> page off, `lower_rom_base`=1, `lower_rom_sel`=1. A later mem write &4000 -> no `asic_ram_wr`.
- Page on, `asic_valid` drops -> `asic_page_en`=0 in the next cycle. Reset asserted during RD_WAIT -> no valid pulse, `cpu_data_out`=&FF.
